// File: rtl/snake_pkg.sv
// Shared snake game constants and direction encoding, used by the movement block,
// the body scanner and the food placer.
package snake_pkg;

  localparam int unsigned GRID_W   = 32;
  localparam int unsigned GRID_H   = 24;
  localparam int unsigned MAX_LEN  = 64;
  localparam int unsigned POS_BITS = $clog2(GRID_W * GRID_H);

  typedef enum logic [1:0] {
    DirUp    = 2'b00,
    DirRight = 2'b01,
    DirDown  = 2'b10,
    DirLeft  = 2'b11
  } dir_e;

endpackage

// File: rtl/snake_seg_mux.sv
// Combinational select of one segment position out of the flattened snake body vector.
module snake_seg_mux #(
  parameter int unsigned POS_BITS = snake_pkg::POS_BITS,
  parameter int unsigned MAX_LEN  = snake_pkg::MAX_LEN,
  parameter int unsigned IDX_BITS = $clog2(snake_pkg::MAX_LEN) + 1
) (
  input  logic [POS_BITS*MAX_LEN-1:0] body_flat,
  input  logic [IDX_BITS-1:0]         idx,
  output logic [POS_BITS-1:0]         seg
);

  // Out-of-range indices select zero rather than wrapping.
  always_comb begin
    seg = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (idx == IDX_BITS'(i)) begin
        seg = body_flat[i*POS_BITS +: POS_BITS];
      end
    end
  end

endmodule

// File: rtl/snake_body_scanner.sv
// Scans a snapshot of the snake body one segment per clock, reporting self-collision,
// occupancy of a query cell and an out-of-bounds head.
module snake_body_scanner #(
  parameter int unsigned GRID_W   = snake_pkg::GRID_W,
  parameter int unsigned GRID_H   = snake_pkg::GRID_H,
  parameter int unsigned MAX_LEN  = snake_pkg::MAX_LEN,
  parameter int unsigned POS_BITS = $clog2(GRID_W * GRID_H),
  localparam int unsigned LEN_BITS = $clog2(MAX_LEN) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [POS_BITS-1:0]          snake_head,
  input  logic [LEN_BITS-1:0]          snake_length,
  input  logic [POS_BITS*MAX_LEN-1:0]  snake_body_flat,
  input  logic [POS_BITS-1:0]          query_pos,
  output logic                         busy,
  output logic                         done,
  output logic                         self_hit,
  output logic                         query_hit,
  output logic                         head_oob
);

  localparam int unsigned NumCells = GRID_W * GRID_H;

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } state_e;

  state_e                      state_q, state_d;
  logic [LEN_BITS-1:0]         idx_q, idx_d;
  logic [LEN_BITS-1:0]         len_q, len_d;
  logic [POS_BITS-1:0]         head_q, head_d;
  logic [POS_BITS-1:0]         query_q, query_d;
  logic [POS_BITS*MAX_LEN-1:0] body_q, body_d;
  logic                        self_hit_q, self_hit_d;
  logic                        query_hit_q, query_hit_d;
  logic                        head_oob_q, head_oob_d;
  logic                        done_q, done_d;

  logic [LEN_BITS-1:0] len_clamped;
  logic                head_oob_now;
  logic                last_seg;
  logic [POS_BITS-1:0] seg;

  snake_seg_mux #(
    .POS_BITS (POS_BITS),
    .MAX_LEN  (MAX_LEN),
    .IDX_BITS (LEN_BITS)
  ) u_seg_mux (
    .body_flat (body_q),
    .idx       (idx_q),
    .seg       (seg)
  );

  assign len_clamped  = (snake_length > LEN_BITS'(MAX_LEN)) ? LEN_BITS'(MAX_LEN) : snake_length;
  assign head_oob_now = 32'(snake_head) >= NumCells;
  assign last_seg     = (idx_q == len_q - LEN_BITS'(1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    head_d      = head_q;
    query_d     = query_q;
    body_d      = body_q;
    self_hit_d  = self_hit_q;
    query_hit_d = query_hit_q;
    head_oob_d  = head_oob_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          head_d      = snake_head;
          query_d     = query_pos;
          body_d      = snake_body_flat;
          len_d       = len_clamped;
          self_hit_d  = 1'b0;
          query_hit_d = 1'b0;
          head_oob_d  = head_oob_now;
          idx_d       = '0;
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (seg == query_q) begin
          query_hit_d = 1'b1;
        end
        // Segment 0 is the head itself, so it never counts as a self-collision.
        if ((idx_q != '0) && (seg == head_q)) begin
          self_hit_d = 1'b1;
        end
        idx_d = idx_q + LEN_BITS'(1);
        if (last_seg) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      len_q       <= '0;
      head_q      <= '0;
      query_q     <= '0;
      body_q      <= '0;
      self_hit_q  <= 1'b0;
      query_hit_q <= 1'b0;
      head_oob_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      head_q      <= head_d;
      query_q     <= query_d;
      body_q      <= body_d;
      self_hit_q  <= self_hit_d;
      query_hit_q <= query_hit_d;
      head_oob_q  <= head_oob_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == StScan);
  assign done      = done_q;
  assign self_hit  = self_hit_q;
  assign query_hit = query_hit_q;
  assign head_oob  = head_oob_q;

endmodule
